// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: brings the fabric PLL out of reset, waits for a stable
// synchronized lock, then releases the system and datapath resets in order.
// It re-runs the sequence on loss of lock or on a soft request, and retries a
// bounded number of times before latching FAULT.
// Optional feature macro: PLL_SEQ_LOSS_CNT_EN enables the saturating
// loss-of-lock counter; when it is undefined, loss_cnt reads as zero.
module pll_reset_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_DELAY   = 8,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       soft_rst,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       dp_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        StPllRst = 3'd0,
        StWait   = 3'd1,
        StStable = 3'd2,
        StStage  = 3'd3,
        StRun    = 3'd4,
        StFault  = 3'd5
    } state_e;

    localparam logic [15:0] RstLast    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] LockLast   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] StableLast = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] StageLast  = 16'(STAGE_DELAY - 1);
    localparam logic [3:0]  RetryMax   = 4'(MAX_RETRIES);

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  retry_q, retry_d;
    logic        lock_meta_q, lock_s_q;
    logic        pll_rst_q, pll_rst_d;
    logic        sys_rst_n_q, sys_rst_n_d;
    logic        dp_rst_n_q, dp_rst_n_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next-state, timer, retry and output decode; outputs follow the next state.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            StPllRst: begin
                if (timer_q == RstLast) state_d = StWait;
            end
            StWait: begin
                if (lock_s_q) begin
                    state_d = StStable;
                end else if (timer_q == LockLast) begin
                    if (retry_q == RetryMax) begin
                        state_d = StFault;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = StPllRst;
                    end
                end
            end
            StStable: begin
                // A lock glitch here is not a retry; just wait for lock again.
                if (!lock_s_q) state_d = StWait;
                else if (timer_q == StableLast) state_d = StStage;
            end
            StStage: begin
                if (!lock_s_q) begin
                    state_d = StPllRst;
                end else if (timer_q == StageLast) begin
                    state_d = StRun;
                    retry_d = '0;
                end
            end
            StRun: begin
                if (!lock_s_q) state_d = StPllRst;
            end
            StFault: state_d = StFault;
            default: state_d = StPllRst;
        endcase

        if (soft_rst) begin
            state_d = StPllRst;
            retry_d = '0;
        end

        timer_d = (soft_rst || (state_d != state_q)) ? 16'd0 : timer_q + 16'd1;

        pll_rst_d   = (state_d == StPllRst) || (state_d == StFault);
        sys_rst_n_d = (state_d == StStage) || (state_d == StRun);
        dp_rst_n_d  = (state_d == StRun);
        ready_d     = (state_d == StRun);
        fault_d     = (state_d == StFault);
    end

    // State, timer, retry count and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPllRst;
            timer_q     <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            dp_rst_n_q  <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            dp_rst_n_q  <= dp_rst_n_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic       loss_event;
    logic [7:0] loss_q;

    // A soft request in the same cycle as a loss is not counted as a loss.
    assign loss_event = !soft_rst && !lock_s_q && ((state_q == StStage) || (state_q == StRun));

    // Saturating loss-of-lock event counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (loss_event && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = 8'd0;
`endif

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign dp_rst_n  = dp_rst_n_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign state     = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small cycle parameters.
module tb_pll_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pll_lock;
    logic       soft_rst;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       dp_rst_n;
    logic       ready;
    logic       fault;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int total;
    int bad;

`ifdef PLL_SEQ_LOSS_CNT_EN
    localparam logic [15:0] Loss1 = 16'd1;
`else
    localparam logic [15:0] Loss1 = 16'd0;
`endif

    pll_reset_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .STAGE_DELAY  (3),
        .MAX_RETRIES  (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .soft_rst (soft_rst),
        .pll_rst  (pll_rst),
        .sys_rst_n(sys_rst_n),
        .dp_rst_n (dp_rst_n),
        .ready    (ready),
        .fault    (fault),
        .state    (state),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 16'(state), 16'd0);
        check({tag, "_pll_rst"}, 16'(pll_rst), 16'd1);
        check({tag, "_sys"}, 16'(sys_rst_n), 16'd0);
        check({tag, "_dp"}, 16'(dp_rst_n), 16'd0);
        check({tag, "_ready"}, 16'(ready), 16'd0);
        check({tag, "_fault"}, 16'(fault), 16'd0);
        check({tag, "_retry"}, 16'(retry_cnt), 16'd0);
        check({tag, "_loss"}, 16'(loss_cnt), 16'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b1;
        pll_lock = 1'b0;
        soft_rst = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("rst_hold");
        step(2);
        check_reset_vals("rst_hold_clk");
        rst_n = 1'b1;

        // Clean bring-up: pll_rst held for 4 cycles.
        step(3);
        check("up_pllrst_hi", 16'(pll_rst), 16'd1);
        check("up_state0", 16'(state), 16'd0);
        step(1);
        check("up_pllrst_lo", 16'(pll_rst), 16'd0);
        check("up_wait", 16'(state), 16'd1);
        step(5);
        pll_lock = 1'b1;
        step(3);
        check("up_stable", 16'(state), 16'd2);
        step(7);
        check("up_sys_lo10", 16'(sys_rst_n), 16'd0);
        step(1);
        check("up_sys_hi11", 16'(sys_rst_n), 16'd1);
        check("up_stage", 16'(state), 16'd3);
        step(2);
        check("up_dp_lo", 16'(dp_rst_n), 16'd0);
        step(1);
        check("up_dp_hi", 16'(dp_rst_n), 16'd1);
        check("up_ready", 16'(ready), 16'd1);
        check("up_run", 16'(state), 16'd4);
        check("up_retry", 16'(retry_cnt), 16'd0);

        // Lock loss in RUN: resets low by the third edge.
        pll_lock = 1'b0;
        step(2);
        check("loss_still_run", 16'(state), 16'd4);
        step(1);
        check("loss_state", 16'(state), 16'd0);
        check("loss_sys", 16'(sys_rst_n), 16'd0);
        check("loss_dp", 16'(dp_rst_n), 16'd0);
        check("loss_pllrst", 16'(pll_rst), 16'd1);
        check("loss_cnt1", 16'(loss_cnt), Loss1);
        pll_lock = 1'b1;
        step(4);
        check("relock_wait", 16'(state), 16'd1);
        step(1);
        check("relock_stable", 16'(state), 16'd2);
        step(8);
        check("relock_stage", 16'(state), 16'd3);
        step(3);
        check("relock_run", 16'(state), 16'd4);
        check("relock_ready", 16'(ready), 16'd1);

        // Soft restart from RUN, then a lock glitch during STABLE.
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        check("soft_run_state", 16'(state), 16'd0);
        check("soft_run_loss", 16'(loss_cnt), Loss1);
        step(4);
        step(1);
        check("gl_stable", 16'(state), 16'd2);
        step(3);
        pll_lock = 1'b0;
        step(2);
        pll_lock = 1'b1;
        step(1);
        check("gl_wait", 16'(state), 16'd1);
        check("gl_retry", 16'(retry_cnt), 16'd0);
        check("gl_sys", 16'(sys_rst_n), 16'd0);
        step(2);
        check("gl_restable", 16'(state), 16'd2);
        step(7);
        check("gl_window", 16'(state), 16'd2);
        check("gl_window_sys", 16'(sys_rst_n), 16'd0);
        step(1);
        check("gl_stage", 16'(state), 16'd3);
        step(3);
        check("gl_run", 16'(state), 16'd4);

        // Soft request coinciding with synchronized lock loss: not counted.
        pll_lock = 1'b0;
        step(2);
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        check("sl_state", 16'(state), 16'd0);
        check("sl_loss", 16'(loss_cnt), Loss1);

        // No lock: three WAIT windows, then FAULT.
        step(4);
        check("nl_wait0", 16'(state), 16'd1);
        step(19);
        check("nl_wait0_end", 16'(state), 16'd1);
        check("nl_retry0", 16'(retry_cnt), 16'd0);
        step(1);
        check("nl_rst1", 16'(state), 16'd0);
        check("nl_retry1", 16'(retry_cnt), 16'd1);
        step(4);
        step(19);
        check("nl_wait1_end", 16'(state), 16'd1);
        step(1);
        check("nl_retry2", 16'(retry_cnt), 16'd2);
        step(4);
        step(19);
        check("nl_wait2_end", 16'(state), 16'd1);
        step(1);
        check("nl_fault_state", 16'(state), 16'd5);
        check("nl_fault", 16'(fault), 16'd1);
        check("nl_pllrst", 16'(pll_rst), 16'd1);
        check("nl_sys", 16'(sys_rst_n), 16'd0);
        step(5);
        check("nl_fault_hold", 16'(state), 16'd5);

        // Soft restart out of FAULT.
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        check("sf_state", 16'(state), 16'd0);
        check("sf_fault", 16'(fault), 16'd0);
        check("sf_retry", 16'(retry_cnt), 16'd0);
        check("sf_loss", 16'(loss_cnt), Loss1);

        // Asynchronous reset while in STAGE.
        pll_lock = 1'b1;
        step(4);
        step(1);
        step(8);
        check("ar_stage", 16'(state), 16'd3);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("ar");
        step(1);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
